// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StRedir   = 2'd2,
        StTrap    = 2'd3
    } state_e;

    // Register x0 is hardwired to zero and never a forwarding source.
    localparam logic [4:0] RegX0 = 5'd0;

endpackage

// File: rtl/hazard_fwd_match.sv
// Register-index match between ID sources and EX/LS destinations; produces the
// ID-stage operand forward selects and the load-use hazard.
module hazard_fwd_match
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_rs1_cen_i,
    input  logic       id_rs2_cen_i,
    input  logic       ex_rd_wen_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       ex_mem_read_i,
    input  logic       ls_rd_wen_i,
    input  logic [4:0] ls_rd_addr_i,
    output logic       fwd_ex_rs1_o,
    output logic       fwd_ex_rs2_o,
    output logic       fwd_ls_rs1_o,
    output logic       fwd_ls_rs2_o,
    output logic       load_use_o
);

    logic hit_ex_rs1, hit_ex_rs2, hit_ls_rs1, hit_ls_rs2;

    // Match producers to consumers; EX is younger so it wins over LS, and a load
    // in EX has no data yet so it cannot forward (load-use stall instead).
    always_comb begin
        hit_ex_rs1 = ex_rd_wen_i && (ex_rd_addr_i != RegX0) &&
                     (ex_rd_addr_i == id_rs1_addr_i) && id_rs1_cen_i;
        hit_ex_rs2 = ex_rd_wen_i && (ex_rd_addr_i != RegX0) &&
                     (ex_rd_addr_i == id_rs2_addr_i) && id_rs2_cen_i;
        hit_ls_rs1 = ls_rd_wen_i && (ls_rd_addr_i != RegX0) &&
                     (ls_rd_addr_i == id_rs1_addr_i) && id_rs1_cen_i;
        hit_ls_rs2 = ls_rd_wen_i && (ls_rd_addr_i != RegX0) &&
                     (ls_rd_addr_i == id_rs2_addr_i) && id_rs2_cen_i;

        fwd_ex_rs1_o = hit_ex_rs1 & ~ex_mem_read_i;
        fwd_ex_rs2_o = hit_ex_rs2 & ~ex_mem_read_i;
        fwd_ls_rs1_o = hit_ls_rs1 & ~hit_ex_rs1;
        fwd_ls_rs2_o = hit_ls_rs2 & ~hit_ex_rs2;
        load_use_o   = ex_mem_read_i & (hit_ex_rs1 | hit_ex_rs2);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush sequencer for the 5-stage core. Drives IF/ID
// stall and ID/EX flush enables, the IFU PC override for ID jumps and traps,
// a stall performance counter and a sticky memory-wait watchdog.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 1024,
    parameter int unsigned CNT_W       = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_cen_i,
    input  logic             id_rs2_cen_i,
    input  logic             id_jump_i,
    input  logic [63:0]      id_jump_pc_i,
    input  logic             ex_rd_wen_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_mem_read_i,
    input  logic             ls_rd_wen_i,
    input  logic [4:0]       ls_rd_addr_i,
    input  logic             ls_mem_read_i,
    input  logic             lsu_busy_i,
    input  logic             ifu_ready_i,
    input  logic             trap_req_i,
    input  logic [63:0]      trap_pc_i,
    output logic             forward_ex_rs1_o,
    output logic             forward_ex_rs2_o,
    output logic             forward_ls_rs1_o,
    output logic             forward_ls_rs2_o,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             redirect_valid_o,
    output logic [63:0]      redirect_pc_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             mem_timeout_o
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              entry_q;
    logic              trap_pend_q, trap_pend_d;
    logic [63:0]       redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              timeout_q;

    logic fwd_ex_rs1, fwd_ex_rs2, fwd_ls_rs1, fwd_ls_rs2, load_use_raw, load_use;

    // The IDU selects LS rd data vs. memory data itself.
    logic unused_ls_mem_read;
    assign unused_ls_mem_read = ls_mem_read_i;

    hazard_fwd_match u_fwd_match (
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_cen_i  (id_rs1_cen_i),
        .id_rs2_cen_i  (id_rs2_cen_i),
        .ex_rd_wen_i   (ex_rd_wen_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_mem_read_i (ex_mem_read_i),
        .ls_rd_wen_i   (ls_rd_wen_i),
        .ls_rd_addr_i  (ls_rd_addr_i),
        .fwd_ex_rs1_o  (fwd_ex_rs1),
        .fwd_ex_rs2_o  (fwd_ex_rs2),
        .fwd_ls_rs1_o  (fwd_ls_rs1),
        .fwd_ls_rs2_o  (fwd_ls_rs2),
        .load_use_o    (load_use_raw)
    );

    // Combinational hazard outputs are held low while reset is asserted.
    always_comb begin
        forward_ex_rs1_o = fwd_ex_rs1 & rst_n;
        forward_ex_rs2_o = fwd_ex_rs2 & rst_n;
        forward_ls_rs1_o = fwd_ls_rs1 & rst_n;
        forward_ls_rs2_o = fwd_ls_rs2 & rst_n;
        load_use         = load_use_raw & rst_n;
    end

    // State, entry flag, pending trap and redirect target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            entry_q       <= 1'b0;
            trap_pend_q   <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            entry_q       <= (state_d != state_q);
            trap_pend_q   <= trap_pend_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Next state: trap > lsu_busy > load_use > jump. A jump under load-use is
    // dropped because its compare used stale operands; ID re-resolves it.
    always_comb begin
        state_d       = state_q;
        trap_pend_d   = trap_pend_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            StRun: begin
                if (trap_req_i) begin
                    state_d       = StTrap;
                    redirect_pc_d = trap_pc_i;
                end else if (lsu_busy_i) begin
                    state_d = StMemWait;
                end else if (!load_use && id_jump_i) begin
                    state_d       = StRedir;
                    redirect_pc_d = id_jump_pc_i;
                end
            end
            StMemWait: begin
                // Trap requests are single-cycle pulses; hold the first one.
                if (trap_req_i && !trap_pend_q) begin
                    trap_pend_d   = 1'b1;
                    redirect_pc_d = trap_pc_i;
                end
                if (!lsu_busy_i) begin
                    state_d     = trap_pend_d ? StTrap : StRun;
                    trap_pend_d = 1'b0;
                end
            end
            StRedir, StTrap: begin
                if (ifu_ready_i) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Stall/flush/redirect enables; flushes fire only on the first cycle in a
    // redirect state (entry_q).
    always_comb begin
        stall_if_o       = 1'b0;
        stall_id_o       = 1'b0;
        flush_id_o       = 1'b0;
        flush_ex_o       = 1'b0;
        redirect_valid_o = 1'b0;
        unique case (state_q)
            StRun: begin
                if (!trap_req_i && !lsu_busy_i && load_use) begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    flush_ex_o = 1'b1;
                end
            end
            StMemWait: begin
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
            end
            StRedir: begin
                redirect_valid_o = 1'b1;
                flush_id_o       = entry_q;
            end
            StTrap: begin
                redirect_valid_o = 1'b1;
                flush_id_o       = entry_q;
                flush_ex_o       = entry_q;
            end
            default: ;
        endcase
    end

    // Stall performance counter (wraps) and saturating memory-wait watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall_id_o);
            if (!lsu_busy_i) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != WAIT_LAST) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
            if (lsu_busy_i && (wait_cnt_q == WAIT_LAST)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign redirect_pc_o = redirect_pc_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors with literal expectations, plus a
// behavioural model checked against every output on each falling edge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MT = 8;
    localparam int unsigned CW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs1_addr_i, id_rs2_addr_i;
    logic          id_rs1_cen_i, id_rs2_cen_i, id_jump_i;
    logic [63:0]   id_jump_pc_i;
    logic          ex_rd_wen_i, ex_mem_read_i, ls_rd_wen_i, ls_mem_read_i;
    logic [4:0]    ex_rd_addr_i, ls_rd_addr_i;
    logic          lsu_busy_i, ifu_ready_i, trap_req_i;
    logic [63:0]   trap_pc_i;
    logic          forward_ex_rs1_o, forward_ex_rs2_o, forward_ls_rs1_o, forward_ls_rs2_o;
    logic          stall_if_o, stall_id_o, flush_id_o, flush_ex_o, redirect_valid_o;
    logic [63:0]   redirect_pc_o;
    logic [CW-1:0] stall_cnt_o;
    logic          mem_timeout_o;

    int n_checks = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs1_addr_i    (id_rs1_addr_i),
        .id_rs2_addr_i    (id_rs2_addr_i),
        .id_rs1_cen_i     (id_rs1_cen_i),
        .id_rs2_cen_i     (id_rs2_cen_i),
        .id_jump_i        (id_jump_i),
        .id_jump_pc_i     (id_jump_pc_i),
        .ex_rd_wen_i      (ex_rd_wen_i),
        .ex_rd_addr_i     (ex_rd_addr_i),
        .ex_mem_read_i    (ex_mem_read_i),
        .ls_rd_wen_i      (ls_rd_wen_i),
        .ls_rd_addr_i     (ls_rd_addr_i),
        .ls_mem_read_i    (ls_mem_read_i),
        .lsu_busy_i       (lsu_busy_i),
        .ifu_ready_i      (ifu_ready_i),
        .trap_req_i       (trap_req_i),
        .trap_pc_i        (trap_pc_i),
        .forward_ex_rs1_o (forward_ex_rs1_o),
        .forward_ex_rs2_o (forward_ex_rs2_o),
        .forward_ls_rs1_o (forward_ls_rs1_o),
        .forward_ls_rs2_o (forward_ls_rs2_o),
        .stall_if_o       (stall_if_o),
        .stall_id_o       (stall_id_o),
        .flush_id_o       (flush_id_o),
        .flush_ex_o       (flush_ex_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .stall_cnt_o      (stall_cnt_o),
        .mem_timeout_o    (mem_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        waiting;     // pipeline frozen behind the LSU
        logic        redir;       // PC override being offered to the IFU
        logic        redir_trap;  // override caused by a trap
        logic        first;       // first cycle of the override
        logic        pend;        // trap seen while waiting on memory
        logic [63:0] pc;
        logic [63:0] stalls;
        logic [31:0] busy_run;    // consecutive busy cycles seen so far
        logic        timeout;
    } model_t;

    model_t m;

    function automatic logic hit(logic wen, logic [4:0] rd, logic [4:0] rs, logic cen);
        return wen && (rd != 5'd0) && (rd == rs) && cen;
    endfunction

    function automatic logic hit_ex1();
        return hit(ex_rd_wen_i, ex_rd_addr_i, id_rs1_addr_i, id_rs1_cen_i);
    endfunction
    function automatic logic hit_ex2();
        return hit(ex_rd_wen_i, ex_rd_addr_i, id_rs2_addr_i, id_rs2_cen_i);
    endfunction
    function automatic logic hit_ls1();
        return hit(ls_rd_wen_i, ls_rd_addr_i, id_rs1_addr_i, id_rs1_cen_i);
    endfunction
    function automatic logic hit_ls2();
        return hit(ls_rd_wen_i, ls_rd_addr_i, id_rs2_addr_i, id_rs2_cen_i);
    endfunction

    function automatic logic lu_now();
        return ex_mem_read_i && (hit_ex1() || hit_ex2());
    endfunction

    function automatic logic exp_stall(model_t s);
        if (s.redir) return 1'b0;
        if (s.waiting) return 1'b1;
        return !trap_req_i && !lsu_busy_i && lu_now();
    endfunction

    function automatic logic exp_flush_ex(model_t s);
        return (s.redir && s.first && s.redir_trap) ||
               (!s.redir && !s.waiting && !trap_req_i && !lsu_busy_i && lu_now());
    endfunction

    function automatic model_t model_next(model_t s);
        model_t n = s;
        n.first = 1'b0;
        if (s.redir) begin
            if (ifu_ready_i) n.redir = 1'b0;
        end else if (s.waiting) begin
            if (trap_req_i && !s.pend) begin
                n.pend = 1'b1;
                n.pc   = trap_pc_i;
            end
            if (!lsu_busy_i) begin
                n.waiting = 1'b0;
                if (n.pend) begin
                    n.redir = 1'b1; n.redir_trap = 1'b1; n.first = 1'b1; n.pend = 1'b0;
                end
            end
        end else if (trap_req_i) begin
            n.redir = 1'b1; n.redir_trap = 1'b1; n.first = 1'b1; n.pc = trap_pc_i;
        end else if (lsu_busy_i) begin
            n.waiting = 1'b1;
        end else if (id_jump_i && !lu_now()) begin
            n.redir = 1'b1; n.redir_trap = 1'b0; n.first = 1'b1; n.pc = id_jump_pc_i;
        end
        n.stalls   = s.stalls + 64'(exp_stall(s));
        n.busy_run = lsu_busy_i ? s.busy_run + 32'd1 : 32'd0;
        if (n.busy_run >= MT) n.timeout = 1'b1;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m);
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check1("fwd_ex_rs1", forward_ex_rs1_o, hit_ex1() && !ex_mem_read_i);
            check1("fwd_ex_rs2", forward_ex_rs2_o, hit_ex2() && !ex_mem_read_i);
            check1("fwd_ls_rs1", forward_ls_rs1_o, hit_ls1() && !hit_ex1());
            check1("fwd_ls_rs2", forward_ls_rs2_o, hit_ls2() && !hit_ex2());
            check1("stall_if", stall_if_o, exp_stall(m));
            check1("stall_id", stall_id_o, exp_stall(m));
            check1("flush_id", flush_id_o, m.redir && m.first);
            check1("flush_ex", flush_ex_o, exp_flush_ex(m));
            check1("redirect_valid", redirect_valid_o, m.redir);
            if (m.redir) check64("redirect_pc", redirect_pc_o, m.pc);
            check64("stall_cnt", stall_cnt_o, m.stalls);
            check1("mem_timeout", mem_timeout_o, m.timeout);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        id_rs1_addr_i = '0; id_rs2_addr_i = '0; id_rs1_cen_i = 0; id_rs2_cen_i = 0;
        id_jump_i = 0; id_jump_pc_i = '0;
        ex_rd_wen_i = 0; ex_rd_addr_i = '0; ex_mem_read_i = 0;
        ls_rd_wen_i = 0; ls_rd_addr_i = '0; ls_mem_read_i = 0;
        lsu_busy_i = 0; ifu_ready_i = 0; trap_req_i = 0; trap_pc_i = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        // Reset: hazard inputs active, outputs must stay quiet.
        idle();
        ex_rd_wen_i = 1; ex_rd_addr_i = 5'd5; id_rs1_addr_i = 5'd5; id_rs1_cen_i = 1;
        #2;
        check1("rst_fwd_ex_rs1", forward_ex_rs1_o, 1'b0);
        check1("rst_redirect_valid", redirect_valid_o, 1'b0);
        check64("rst_redirect_pc", redirect_pc_o, 64'h0);
        check64("rst_stall_cnt", stall_cnt_o, 64'h0);
        check1("rst_mem_timeout", mem_timeout_o, 1'b0);
        ex_mem_read_i = 1;
        #1;
        check1("rst_stall_id", stall_id_o, 1'b0);
        cyc();
        rst_n = 1;

        // ALU result to branch compare, then the same with rd=x0.
        cyc(); ex_rd_wen_i = 1; ex_rd_addr_i = 5'd5; id_rs1_addr_i = 5'd5; id_rs1_cen_i = 1;
        #3; check1("alu_fwd_ex_rs1", forward_ex_rs1_o, 1'b1);
        check1("alu_no_stall", stall_id_o, 1'b0);
        cyc(); ex_rd_wen_i = 1; id_rs1_cen_i = 1; id_rs2_cen_i = 1; ls_rd_wen_i = 1;
        #3; check1("x0_fwd_ex_rs1", forward_ex_rs1_o, 1'b0);
        check1("x0_fwd_ls_rs1", forward_ls_rs1_o, 1'b0);
        check1("x0_fwd_ex_rs2", forward_ex_rs2_o, 1'b0);

        // Load-use: one stall cycle, then forward from LS.
        cyc(); ex_rd_wen_i = 1; ex_rd_addr_i = 5'd7; ex_mem_read_i = 1;
        id_rs2_addr_i = 5'd7; id_rs2_cen_i = 1;
        #3; check1("lu_stall_if", stall_if_o, 1'b1);
        check1("lu_stall_id", stall_id_o, 1'b1);
        check1("lu_flush_ex", flush_ex_o, 1'b1);
        check1("lu_fwd_ex_rs2", forward_ex_rs2_o, 1'b0);
        cyc(); ls_rd_wen_i = 1; ls_rd_addr_i = 5'd7; ls_mem_read_i = 1;
        id_rs2_addr_i = 5'd7; id_rs2_cen_i = 1;
        #3; check1("lu_fwd_ls_rs2", forward_ls_rs2_o, 1'b1);
        check1("lu_released", stall_id_o, 1'b0);
        check64("lu_stall_cnt", stall_cnt_o, 64'd1);

        // Double hit: EX wins.
        cyc(); ex_rd_wen_i = 1; ex_rd_addr_i = 5'd3; ls_rd_wen_i = 1; ls_rd_addr_i = 5'd3;
        id_rs1_addr_i = 5'd3; id_rs1_cen_i = 1;
        #3; check1("dbl_fwd_ex_rs1", forward_ex_rs1_o, 1'b1);
        check1("dbl_fwd_ls_rs1", forward_ls_rs1_o, 1'b0);

        // Jump with IFU not ready for two cycles.
        cyc(); id_jump_i = 1; id_jump_pc_i = 64'h8000_0100;
        #3; check1("jmp_c0_valid", redirect_valid_o, 1'b0);
        cyc();
        #3; check1("jmp_c1_valid", redirect_valid_o, 1'b1);
        check64("jmp_c1_pc", redirect_pc_o, 64'h8000_0100);
        check1("jmp_c1_flush_id", flush_id_o, 1'b1);
        cyc();
        #3; check1("jmp_c2_valid", redirect_valid_o, 1'b1);
        check1("jmp_c2_flush_id", flush_id_o, 1'b0);
        cyc(); ifu_ready_i = 1;
        #3; check1("jmp_c3_valid", redirect_valid_o, 1'b1);
        cyc();
        #3; check1("jmp_done_valid", redirect_valid_o, 1'b0);

        // Trap arriving while waiting on memory, taken after busy drops.
        cyc(); lsu_busy_i = 1;
        #3; check1("mw_first_no_stall", stall_id_o, 1'b0);
        cyc(); lsu_busy_i = 1;
        #3; check1("mw_stall", stall_id_o, 1'b1);
        cyc(); lsu_busy_i = 1; trap_req_i = 1; trap_pc_i = 64'h8000_0004;
        #3; check1("mw_trap_held", redirect_valid_o, 1'b0);
        cyc(); lsu_busy_i = 1;
        cyc();
        #3; check1("mw_exit_stall", stall_id_o, 1'b1);
        check1("mw_exit_valid", redirect_valid_o, 1'b0);
        cyc(); ifu_ready_i = 1;
        #3; check1("trap_flush_id", flush_id_o, 1'b1);
        check1("trap_flush_ex", flush_ex_o, 1'b1);
        check1("trap_valid", redirect_valid_o, 1'b1);
        check64("trap_pc", redirect_pc_o, 64'h8000_0004);
        cyc();
        #3; check1("trap_done", redirect_valid_o, 1'b0);
        check64("mw_stall_cnt", stall_cnt_o, 64'd5);

        // Trap + jump + load-use together: trap wins, no stall.
        cyc(); trap_req_i = 1; trap_pc_i = 64'h100; id_jump_i = 1; id_jump_pc_i = 64'h200;
        ex_rd_wen_i = 1; ex_rd_addr_i = 5'd9; ex_mem_read_i = 1;
        id_rs1_addr_i = 5'd9; id_rs1_cen_i = 1;
        #3; check1("coin_no_stall", stall_id_o, 1'b0);
        cyc();
        #3; check64("coin_pc", redirect_pc_o, 64'h100);
        check1("coin_flush_ex", flush_ex_o, 1'b1);
        cyc(); ifu_ready_i = 1;
        // Jump under load-use is not taken.
        cyc(); id_jump_i = 1; id_jump_pc_i = 64'h300;
        ex_rd_wen_i = 1; ex_rd_addr_i = 5'd9; ex_mem_read_i = 1;
        id_rs1_addr_i = 5'd9; id_rs1_cen_i = 1;
        #3; check1("jlu_stall", stall_id_o, 1'b1);
        cyc();
        #3; check1("jlu_no_redirect", redirect_valid_o, 1'b0);

        // Watchdog: 7 busy cycles stay below the limit, 8 trip it.
        repeat (7) begin cyc(); lsu_busy_i = 1; end
        cyc();
        #3; check1("wd_7_clear", mem_timeout_o, 1'b0);
        repeat (8) begin cyc(); lsu_busy_i = 1; end
        cyc();
        #3; check1("wd_8_set", mem_timeout_o, 1'b1);
        repeat (3) cyc();
        #3; check1("wd_sticky", mem_timeout_o, 1'b1);
        check64("wd_stall_cnt", stall_cnt_o, 64'd21);

        // Reset in the middle of a redirect drops everything at once.
        cyc(); id_jump_i = 1; id_jump_pc_i = 64'h400;
        cyc();
        #2; check1("rr_valid_before", redirect_valid_o, 1'b1);
        #1; rst_n = 0;
        #1; check1("rr_valid_dropped", redirect_valid_o, 1'b0);
        check1("rr_timeout_cleared", mem_timeout_o, 1'b0);
        check64("rr_stall_cnt", stall_cnt_o, 64'd0);
        check64("rr_pc", redirect_pc_o, 64'd0);
        cyc(); rst_n = 1;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard, forwarding and flush sequencer for the 5-stage core (IF/ID/EX/LS/WB); branches and jumps resolve in ID.
- Generates operand-forward selects for ID branch compare logic, load-use and memory-busy stalls, ID jump redirects and trap redirects.
- Keeps a stall performance counter and a memory-wait watchdog.
- Sits beside the pipeline registers and drives their stall/flush enables and the IFU next-PC override.

Parameters:
- MEM_TIMEOUT, 1024, cycles of continuous lsu_busy_i before mem_timeout_o sets.
- CNT_W, 64, width of stall_cnt_o.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1_addr_i  in  5  ID rs1 index
- id_rs2_addr_i  in  5  ID rs2 index
- id_rs1_cen_i  in  1  ID reads rs1
- id_rs2_cen_i  in  1  ID reads rs2
- id_jump_i  in  1  ID resolved taken branch/jal/jalr
- id_jump_pc_i  in  64  ID jump target
- ex_rd_wen_i  in  1  EX writes rd
- ex_rd_addr_i  in  5  EX rd
- ex_mem_read_i  in  1  EX holds a load
- ls_rd_wen_i  in  1  LS writes rd
- ls_rd_addr_i  in  5  LS rd
- ls_mem_read_i  in  1  LS holds a load
- lsu_busy_i  in  1  LSU memory access pending
- ifu_ready_i  in  1  IFU accepts a redirect this cycle
- trap_req_i  in  1  CSR unit raises ecall/ebreak/mret/interrupt (1-cycle pulse)
- trap_pc_i  in  64  trap/mret target
- forward_ex_rs1_o / forward_ex_rs2_o  out  1  select EX result
- forward_ls_rs1_o / forward_ls_rs2_o  out  1  select LS result (IDU picks rd data vs mem data from ls_mem_read)
- stall_if_o, stall_id_o  out  1  hold IF/ID registers
- flush_id_o, flush_ex_o  out  1  insert bubble into ID/EX registers
- redirect_valid_o  out  1  IFU PC override
- redirect_pc_o  out  64  override target
- stall_cnt_o  out  CNT_W  cycles with stall_id_o high
- mem_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset state: fsm RUN, redirect_valid_o 0, redirect_pc_o 0, stall_cnt_o 0, mem_timeout_o 0, wait counter 0. All combinational outputs deassert in reset.
- Match rule, per stage X in {EX, LS} and N in {1,2}: hitX_N = X_rd_wen & X_rd_addr!=0 & X_rd_addr==id_rsN_addr & id_rsN_cen.
- forward_ex_rsN_o = hitEX_N & ~ex_mem_read_i.
- forward_ls_rsN_o = hitLS_N & ~hitEX_N, so EX has priority. Forward outputs are combinational and zero-latency.
- Load-use: load_use = ex_mem_read_i & (hitEX_1 | hitEX_2). Stalls exactly 1 cycle; the next cycle sees the producer in LS and forwards from it.
- FSM states and transitions:
  - RUN:
    - trap_req_i -> TRAP.
    - else lsu_busy_i -> MEMWAIT.
    - else load_use -> stay in RUN with stall_if/stall_id/flush_ex high for that cycle.
    - else id_jump_i -> REDIR.
  - MEMWAIT: stall_if, stall_id high; flush_ex low (EX/LS frozen by LSU). Leaves to RUN the first cycle lsu_busy_i is low. trap_req_i during MEMWAIT is latched and taken on exit.
  - REDIR: redirect_valid_o=1 with redirect_pc_o latched from id_jump_pc_i on entry; flush_id_o=1 on the entry cycle. Holds until ifu_ready_i=1, then returns to RUN.
  - TRAP: flush_id_o and flush_ex_o high on the entry cycle; redirect_valid_o=1, redirect_pc_o=trap_pc_i latched. Holds until ifu_ready_i, then RUN. Further trap_req_i is ignored while in TRAP.
- Priority when events coincide: trap > lsu_busy > load_use > jump.
  - A jump together with load_use is not taken: ID operands are stale, and the branch re-evaluates next cycle.
  - A jump together with a trap is dropped.
- stall_cnt_o: +1 every cycle stall_id_o=1; wraps at 2^CNT_W.
- Watchdog: increments while lsu_busy_i=1, clears when it is 0. At count==MEM_TIMEOUT-1 with busy still high, mem_timeout_o sets, and it clears only on reset. The counter saturates.
- Reset mid-REDIR/TRAP: redirect drops immediately (async).

Decomposition:
- Shared package/defines: FSM state encodings (RUN, MEMWAIT, REDIR, TRAP, 2-bit) and the x0 constant.
- Natural sub-module: hazard_fwd_match, the combinational hitX_N and forward logic, instantiated once.
- The FSM, counters and redirect registers stay in the top module.

Test Plan:
- ALU-to-branch forward: EX rd=5 wen, ID beq rs1=5 -> forward_ex_rs1_o=1, no stall. Same case with rd=0 -> all forwards 0.
- Load-use: EX lw rd=7 mem_read, ID add rs2=7 -> stall_if/id, flush_ex for 1 cycle. Next cycle LS rd=7 -> forward_ls_rs2_o=1, stall_cnt_o=1.
- Double hit: EX and LS both rd=3, ID rs1=3 -> forward_ex_rs1_o=1, forward_ls_rs1_o=0.
- Jump: id_jump_i with pc 0x8000_0100 and ifu_ready_i low 2 cycles -> redirect_valid_o high 3 cycles with that pc; flush_id_o only on the first cycle.
- Trap during MEMWAIT: lsu_busy 4 cycles, trap_req at cycle 2 with pc 0x8000_0004 -> TRAP entered after busy drops; flush_id/ex pulse, then redirect to 0x8000_0004.
- Watchdog with MEM_TIMEOUT=8: lsu_busy held 8 cycles -> mem_timeout_o set and stays 1 after busy drops; cleared only by rst_n low.
